// File: rtl/ps_pc_stck_cntrl_pkg.sv
// rtl/ps_pc_stck_cntrl_pkg.sv - shared constants and event decode for the PC stack controller
package ps_pkg;

  localparam int PS_DEPTH = 16;
  localparam int PS_AW    = 4;
  localparam int PS_DW    = 16;

  localparam logic [3:0] PCSTK_UREG_ADD = 4'b0110;

  localparam logic [2:0] EV_NONE = 3'd0;
  localparam logic [2:0] EV_PUSH = 3'd1;
  localparam logic [2:0] EV_POP  = 3'd2;
  localparam logic [2:0] EV_SWAP = 3'd3;
  localparam logic [2:0] EV_UW   = 3'd4;
  localparam logic [2:0] EV_UR   = 3'd5;

  // Only the highest-priority request of a cycle is acted on; the rest are dropped.
  function automatic logic [2:0] ev_decode(input logic push, input logic pop,
                                           input logic uw, input logic ur);
    if (push && pop) return EV_SWAP;
    if (push)        return EV_PUSH;
    if (pop)         return EV_POP;
    if (uw)          return EV_UW;
    if (ur)          return EV_UR;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/ps_pc_stck_cntrl_if.sv
// rtl/ps_pc_stck_cntrl_if.sv - decode-stage request and status bundle of the PC stack
interface ps_pc_stck_cntrl_if
  import ps_pkg::*;
#(
  parameter int AW = PS_AW,
  parameter int DW = PS_DW
) ();

  logic          ps_pshstck;
  logic          ps_popstck;
  logic [DW-1:0] ps_pc_nxt;
  logic          ps_urgtrnsinst;
  logic          ps_ureg_wr;
  logic [3:0]    ps_ureg_add;
  logic [DW-1:0] ps_ureg_din;
  logic          ps_stck_clr;
  logic [DW-1:0] ps_stck_dout;
  logic          ps_stck_vld;
  logic [AW:0]   ps_stck_ptr;
  logic          ps_stck_empty;
  logic          ps_stck_full;
  logic          ps_stck_ovf;
  logic          ps_stck_unf;

  modport master (
    output ps_pshstck, ps_popstck, ps_pc_nxt, ps_urgtrnsinst, ps_ureg_wr,
           ps_ureg_add, ps_ureg_din, ps_stck_clr,
    input  ps_stck_dout, ps_stck_vld, ps_stck_ptr, ps_stck_empty, ps_stck_full,
           ps_stck_ovf, ps_stck_unf
  );

  modport slave (
    input  ps_pshstck, ps_popstck, ps_pc_nxt, ps_urgtrnsinst, ps_ureg_wr,
           ps_ureg_add, ps_ureg_din, ps_stck_clr,
    output ps_stck_dout, ps_stck_vld, ps_stck_ptr, ps_stck_empty, ps_stck_full,
           ps_stck_ovf, ps_stck_unf
  );

endinterface

// File: rtl/ps_pc_stck_cntrl_mem.sv
// rtl/ps_pc_stck_cntrl_mem.sv - return-address register file, one write port, async TOS read
module ps_stck_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ps_pc_stck_cntrl.sv
// rtl/ps_pc_stck_cntrl.sv - PC stack controller: push/pop/swap sequencing, PCSTK ureg access, error flags
module ps_pc_stck_cntrl
  import ps_pkg::*;
#(
  parameter int DEPTH = PS_DEPTH,
  parameter int AW    = PS_AW,
  parameter int DW    = PS_DW
) (
  input  logic         clk,
  input  logic         rst_n,
  ps_pc_stck_cntrl_if.slave bus
);

  logic [AW:0]   ptr, ptr_nxt;
  logic [DW-1:0] dout, dout_nxt;
  logic          vld, vld_nxt;
  logic          ovf, unf, ovf_set, unf_set;
  logic          empty, full;
  logic          uw, ur;
  logic [2:0]    ev;
  logic          we;
  logic [AW-1:0] tos_idx, wr_idx;
  logic [DW-1:0] wr_data, rd_data;

  assign empty   = (ptr == '0);
  assign full    = (ptr == (AW+1)'(DEPTH));
  // When full the low bits wrap to 0, so TOS still lands on DEPTH-1.
  assign tos_idx = ptr[AW-1:0] - AW'(1);

  assign uw = bus.ps_urgtrnsinst &  bus.ps_ureg_wr & (bus.ps_ureg_add == PCSTK_UREG_ADD);
  assign ur = bus.ps_urgtrnsinst & ~bus.ps_ureg_wr & (bus.ps_ureg_add == PCSTK_UREG_ADD);
  assign ev = ev_decode(bus.ps_pshstck, bus.ps_popstck, uw, ur);

  always_comb begin
    ptr_nxt  = ptr;
    dout_nxt = dout;
    vld_nxt  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    we       = 1'b0;
    wr_idx   = tos_idx;
    wr_data  = bus.ps_pc_nxt;
    case (ev)
      EV_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          wr_idx  = ptr[AW-1:0];
          ptr_nxt = ptr + (AW+1)'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      EV_POP: begin
        if (!empty) begin
          dout_nxt = rd_data;
          ptr_nxt  = ptr - (AW+1)'(1);
          vld_nxt  = 1'b1;
        end else begin
          unf_set  = 1'b1;
        end
      end
      EV_SWAP: begin
        // Return-then-call on an empty stack degrades to a plain push.
        if (!empty) begin
          dout_nxt = rd_data;
          we       = 1'b1;
          vld_nxt  = 1'b1;
        end else begin
          we       = 1'b1;
          wr_idx   = ptr[AW-1:0];
          ptr_nxt  = ptr + (AW+1)'(1);
          unf_set  = 1'b1;
        end
      end
      EV_UW: begin
        wr_data = bus.ps_ureg_din;
        if (!empty) we = 1'b1;
        else        unf_set = 1'b1;
      end
      EV_UR: begin
        vld_nxt = 1'b1;
        if (!empty) begin
          dout_nxt = rd_data;
        end else begin
          dout_nxt = '0;
          unf_set  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      dout <= '0;
      vld  <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      ptr  <= ptr_nxt;
      dout <= dout_nxt;
      vld  <= vld_nxt;
      ovf  <= ovf_set | (ovf & ~bus.ps_stck_clr);
      unf  <= unf_set | (unf & ~bus.ps_stck_clr);
    end
  end

  ps_stck_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_stck_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_idx),
    .wdata (wr_data),
    .raddr (tos_idx),
    .rdata (rd_data)
  );

  assign bus.ps_stck_dout  = dout;
  assign bus.ps_stck_vld   = vld;
  assign bus.ps_stck_ptr   = ptr;
  assign bus.ps_stck_empty = empty;
  assign bus.ps_stck_full  = full;
  assign bus.ps_stck_ovf   = ovf;
  assign bus.ps_stck_unf   = unf;

endmodule
